// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add; DIV/DIVU use restoring division; 32 iterations each.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic        neg_q, rem_neg_q, dz_q;
  logic [31:0] a_q, b_q;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        accept, last, is_div;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, rem_sh, rem_dif;
  logic        ge;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign accept = (state_q == StIdle) && start;
  assign last   = (state_q == StRun) && (cnt_q == 5'd31);
  assign is_div = op_q[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun:  if (cnt_q == 5'd31) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Signed ops work on magnitudes; signs are reapplied on the final edge.
  assign a_neg = op[0] & op_a[31];
  assign b_neg = op[0] & op_b[31];
  assign a_mag = a_neg ? (~op_a + 32'd1) : op_a;
  assign b_mag = b_neg ? (~op_b + 32'd1) : op_b;

  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
    rem_sh  = {acc_q[63:32], a_q[31]};
    ge      = rem_sh >= {1'b0, b_q};
    rem_dif = rem_sh - {1'b0, b_q};
    if (is_div) begin
      acc_d = {(ge ? rem_dif[31:0] : rem_sh[31:0]), acc_q[30:0], ge};
    end else begin
      acc_d = {mul_sum, acc_q[31:1]};
    end
    prod_fix = neg_q ? (~acc_d + 64'd1) : acc_d;
    // A zero divisor still yields remainder == dividend after sign restore.
    quo_fix  = dz_q ? 32'hFFFF_FFFF : (neg_q ? (~acc_d[31:0] + 32'd1) : acc_d[31:0]);
    rem_fix  = rem_neg_q ? (~acc_d[63:32] + 32'd1) : acc_d[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      op_q      <= 2'd0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last;
      if (accept) begin
        op_q      <= op;
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
        dz_q      <= op[1] && (op_b == 32'd0);
        a_q       <= a_mag;
        b_q       <= b_mag;
        acc_q     <= 64'd0;
        cnt_q     <= 5'd0;
      end else if (state_q == StRun) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 5'd1;
        if (is_div) a_q <= {a_q[30:0], 1'b0};
        else        b_q <= {1'b0, b_q[31:1]};
        if (last) begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
        end
      end else begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == StRun);
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] op_a = 32'd0, op_b = 32'd0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] OpMultu = 2'b00, OpMult = 2'b01, OpDivu = 2'b10, OpDiv = 2'b11;

  mult_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .op_a  (op_a),
    .op_b  (op_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts negedges with busy high; returns at the negedge where busy has dropped.
  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic low_we, input logic [31:0] wd,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start = 1'b1; op = o; op_a = a; op_b = b; lo_we = low_we; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    wait_done(n);
    check({tag, " cycles"}, 64'(n), 64'd32);
    check({tag, " done"},   64'(done), 64'd1);
    check({tag, " hi"},     64'(hi), 64'(exp_hi));
    check({tag, " lo"},     64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int n;
    int dones;
    #1;
    check("reset hi",   64'(hi), 64'd0);
    check("reset lo",   64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("multu max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0,
          32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    check("multu done pulse", 64'(done), 64'd0);
    check("multu idle", 64'(busy), 64'd0);

    do_op("mult -3x7", OpMult, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("mult min^2", OpMult, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0,
          32'h4000_0000, 32'h0);
    do_op("divu 100/7", OpDivu, 32'd100, 32'd7, 1'b0, 32'd0, 32'd2, 32'd14);
    do_op("div -7/2", OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div 7/-2", OpDiv, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd0, 32'd1, 32'hFFFF_FFFD);
    do_op("div ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, 32'h8000_0000);
    do_op("divu 5/0", OpDivu, 32'd5, 32'd0, 1'b0, 32'd0, 32'd5, 32'hFFFF_FFFF);
    // Started in the done cycle of the previous op.
    do_op("b2b multu", OpMultu, 32'd6, 32'd7, 1'b0, 32'd0, 32'd0, 32'd42);
    @(negedge clk);

    // Start pulse with new operands mid-operation must be ignored.
    start = 1'b1; op = OpMultu; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 10) begin
        start = 1'b1; op = OpMult; op_a = 32'hFFFF_FFFF; op_b = 32'h1234_5678;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ignored start cycles", 64'(n), 64'd32);
    check("ignored start hi", 64'(hi), 64'd0);
    check("ignored start lo", 64'(lo), 64'd42);
    @(negedge clk);

    // MTHI while busy is dropped.
    start = 1'b1; op = OpMultu; op_a = 32'd2; op_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    wait_done(n);
    check("mthi busy hi", 64'(hi), 64'd0);
    check("mthi busy lo", 64'(lo), 64'd6);
    @(negedge clk);

    // MTHI while idle lands on the next edge and never pulses done.
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    check("mthi idle hi", 64'(hi), 64'h1234_5678);
    check("mthi no done", 64'(done), 64'd0);
    @(negedge clk);
    hi_we = 1'b0;

    // MTLO together with start: start wins.
    start = 1'b1; op = OpMultu; op_a = 32'd3; op_b = 32'd5; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check("mtlo+start lo kept", 64'(lo), 64'h1234_5678 & 64'h0 | 64'd6);
    check("mtlo+start busy", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    wait_done(n);
    check("mtlo+start cycles", 64'(n), 64'd32);
    check("mtlo+start lo", 64'(lo), 64'd15);
    check("mtlo+start hi", 64'(hi), 64'd0);
    @(negedge clk);

    // Asynchronous reset mid-operation.
    start = 1'b1; op = OpMultu; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre-abort busy", 64'(busy), 64'd1);
    check("pre-abort lo", 64'(lo), 64'd15);
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    check("abort idle lo", 64'(lo), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath: executes MULT, MULTU, DIV and DIVU over 32 cycles and holds the 64-bit result in architectural HI/LO registers. It sits directly upstream of the 32-bit 2:1 result mux. `hi` drives its `in_2` and `lo` drives its `in_1`, and the mux `select` picks between them for MFHI/MFLO. The control unit stalls the pipeline while `busy` is high.

## Interface
- No parameters; the width is fixed at 32.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: launch an operation; sampled only when `busy`=0.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start`.
- `op_a` in 32: multiplicand or dividend (rs).
- `op_b` in 32: multiplier or divisor (rt).
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in 32: MTHI/MTLO data.
- `hi` out 32: HI register. Product bits 63:32, or the remainder.
- `lo` out 32: LO register. Product bits 31:0, or the quotient.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; `hi`/`lo` were just updated by an operation.

## Operation
- **FSM states:** IDLE, RUN.
  - IDLE → RUN on `start`=1.
  - RUN → IDLE when iteration counter = 31 at the edge.
- **Load edge (start accepted):**
  - Latch `op`.
  - For signed ops, record the operand signs and convert both operands to magnitudes (two's-complement negate if negative). Unsigned ops load operands as-is.
  - Clear the 64-bit accumulator and the 5-bit counter.
- **Multiply:** shift-add, one multiplier bit per cycle, LSB first. Exactly 32 iterations.
- **Divide:** restoring, one quotient bit per cycle, MSB first. 64-bit remainder/quotient shift register, 33-bit trial subtract.
- **Final edge:** sign correction and the write to HI/LO happen on the same edge.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
- **Divide by zero (`op_b`=0):**
  - Full latency is still taken.
  - Result is `lo`=32'hFFFF_FFFF and `hi`=`op_a` as loaded (unmodified), for both DIV and DIVU.
- **DIV 0x8000_0000 / 0xFFFF_FFFF:** `lo`=0x8000_0000, `hi`=0. No trap.
- **`start` while `busy`=1:** ignored. Operands and `op` are not re-sampled.
- **MTHI/MTLO:**
  - `hi_we`/`lo_we` write `wdata` on the next edge, only when `busy`=0 and `start`=0.
  - If `start` is high in the same cycle, `start` wins and the write is dropped.
  - Writes while busy are dropped.
- **Retention:** `hi`/`lo` hold their value except on a final edge, an MT write, or reset.

## Timing
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- **Reset mid-operation:** aborts immediately (asynchronous). No `done` pulse follows, and `hi`/`lo` read 0.
- **Operation latency:** `start` accepted at edge E0.
  - `busy`=1 after E0 through E32.
  - Iterations run on E1..E32; `hi`/`lo` update at E32.
  - After E32: `busy`=0 and `done`=1 for one cycle.
  - A new `start` may be accepted at E33, i.e. in the same cycle `done` is high.
- **Read-after-MT:** an MT write at edge E is visible on `hi`/`lo` after E.
- **`done` cause:** `done` is asserted only by operation completion, never by MT writes.
- **Output timing:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **MULTU max operands:** MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → `hi`=0xFFFF_FFFE, `lo`=0x0000_0001. `done` is high exactly one cycle, in the cycle after edge E32; `busy` is high for 32 cycles.
- **MULT signed:** MULT −3 (0xFFFF_FFFD) × 7 → `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFEB. MULT 0x8000_0000 × 0x8000_0000 → `hi`=0x4000_0000, `lo`=0.
- **Divide, normal operands:** DIVU 100 / 7 → `lo`=14, `hi`=2. DIV −7 / 2 → `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF. DIV 7 / −2 → `lo`=0xFFFF_FFFD, `hi`=1.
- **Divide corner cases:** DIV 0x8000_0000 / 0xFFFF_FFFF → `lo`=0x8000_0000, `hi`=0. DIVU 5 / 0 → `lo`=0xFFFF_FFFF, `hi`=5. Latency is unchanged at 32 cycles.
- **Ignored start, back-to-back, reset abort:**
  - Pulse `start` with different operands at cycle 10 of a running MULTU 6 × 7. Result is still `hi`=0, `lo`=42.
  - Back-to-back: `start` in the `done` cycle is accepted.
  - Assert `rst_n`=0 at cycle 15 of a later op. `busy`, `done`, `hi`, `lo` go to 0 at once, and no `done` pulse follows release.
- **MT writes:**
  - `hi_we` with `wdata`=0x1234_5678 while busy → dropped.
  - Same write while idle → `hi`=0x1234_5678 after the next edge.
  - `lo_we` together with `start` → write dropped, operation runs.
